// File: rtl/matrix_outer_mult_pkg.sv
// Shared widths and counts for the 3x3 outer-product multiplier.
// Imported by the top level, the multiplier unit and the bench.
package matrix_outer_mult_pkg;

  localparam int DW = 8;
  localparam int PW = 2*DW + 1;
  localparam int NV = 3;
  localparam int NP = NV*NV;

endpackage

// File: rtl/matrix_outer_mult_mult_unit.sv
// Unsigned DW x DW multiplier.
// The result is zero-extended into a PW-bit word with a spare headroom bit.
module mult_unit
  import matrix_outer_mult_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [PW-1:0] p
);

  logic [2*DW-1:0] ax;
  logic [2*DW-1:0] bx;
  logic [2*DW-1:0] m;

  assign ax = {{DW{1'b0}}, a};
  assign bx = {{DW{1'b0}}, b};
  assign m  = ax * bx;
  assign p  = {1'b0, m};

endmodule

// File: rtl/matrix_outer_mult.sv
// Two-stage pipelined 3x3 unsigned outer product, c = a (x) b.
// Stage 1 holds the operands and stage 2 holds the nine products.
module matrix_outer_mult
  import matrix_outer_mult_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] a2,
  input  logic [DW-1:0] a3,
  input  logic [DW-1:0] b1,
  input  logic [DW-1:0] b2,
  input  logic [DW-1:0] b3,
  output logic [PW-1:0] c1,
  output logic [PW-1:0] c2,
  output logic [PW-1:0] c3,
  output logic [PW-1:0] c4,
  output logic [PW-1:0] c5,
  output logic [PW-1:0] c6,
  output logic [PW-1:0] c7,
  output logic [PW-1:0] c8,
  output logic [PW-1:0] c9
);

  logic [NV-1:0][DW-1:0] a_q;
  logic [NV-1:0][DW-1:0] b_q;
  logic [NP-1:0][PW-1:0] p;
  logic [NP-1:0][PW-1:0] c_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= {a3, a2, a1};
      b_q <= {b3, b2, b1};
    end
  end

  // Row-major: product index 3*i+j is a[i]*b[j].
  for (genvar i = 0; i < NV; i++) begin : g_row
    for (genvar j = 0; j < NV; j++) begin : g_col
      mult_unit u_mult (
        .a (a_q[i]),
        .b (b_q[j]),
        .p (p[NV*i+j])
      );
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q <= '0;
    end else begin
      c_q <= p;
    end
  end

  assign c1 = c_q[0];
  assign c2 = c_q[1];
  assign c3 = c_q[2];
  assign c4 = c_q[3];
  assign c5 = c_q[4];
  assign c6 = c_q[5];
  assign c7 = c_q[6];
  assign c8 = c_q[7];
  assign c9 = c_q[8];

endmodule

// File: tb/tb_matrix_outer_mult.sv
// Scoreboard bench for matrix_outer_mult: stimulus queues expected
// products tagged with their due cycle, a monitor compares on negedge.
module tb_matrix_outer_mult;
  import matrix_outer_mult_pkg::*;

  typedef logic [NP-1:0][PW-1:0] vec_t;

  typedef struct {
    int    due;
    vec_t  c;
    string tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] a1, a2, a3, b1, b2, b3;
  logic [PW-1:0] c1, c2, c3, c4, c5, c6, c7, c8, c9;
  vec_t          cv;

  int   ncmp = 0;
  int   nbad = 0;
  int   cyc  = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  matrix_outer_mult dut (
    .clk   (clk),
    .reset (reset),
    .a1    (a1),
    .a2    (a2),
    .a3    (a3),
    .b1    (b1),
    .b2    (b2),
    .b3    (b3),
    .c1    (c1),
    .c2    (c2),
    .c3    (c3),
    .c4    (c4),
    .c5    (c5),
    .c6    (c6),
    .c7    (c7),
    .c8    (c8),
    .c9    (c9)
  );

  assign cv = {c9, c8, c7, c6, c5, c4, c3, c2, c1};

  task automatic cmp(input string tag, input vec_t act, input vec_t exp);
    for (int k = 0; k < NP; k++) begin
      ncmp++;
      if (act[k] !== exp[k]) begin
        nbad++;
        $display("FAIL %s c%0d: got %0d, expected %0d (t=%0t)",
                 tag, k+1, act[k], exp[k], $time);
      end
    end
  endtask

  // Monitor: compare whatever entry is due at this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      if (exp_q[0].due < cyc) begin
        ncmp++;
        nbad++;
        $display("FAIL %s: entry due cycle %0d missed at cycle %0d",
                 exp_q[0].tag, exp_q[0].due, cyc);
      end else begin
        cmp(exp_q[0].tag, cv, exp_q[0].c);
      end
      void'(exp_q.pop_front());
    end
  end

  task automatic drive(input int a[3], input int b[3],
                       input int e[9], input string tag);
    vec_t ev;
    @(negedge clk);
    a1 = a[0][DW-1:0]; a2 = a[1][DW-1:0]; a3 = a[2][DW-1:0];
    b1 = b[0][DW-1:0]; b2 = b[1][DW-1:0]; b3 = b[2][DW-1:0];
    for (int k = 0; k < NP; k++) ev[k] = e[k][PW-1:0];
    exp_q.push_back('{due: cyc + 2, c: ev, tag: tag});
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      ncmp++;
      nbad++;
      $display("FAIL %s drain: %0d left, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 cmp(tag, cv, '0);
    exp_q.delete();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back('{due: cyc + 1, c: '0, tag: "refill0"});
  endtask

  initial begin
    int ra[3];
    int rb[3];
    int re[9];

    a1 = 8'd255; a2 = 8'd3; a3 = 8'd3;
    b1 = 8'd255; b2 = 8'd3; b3 = 8'd3;
    #1 cmp("rst_t0", cv, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cmp("rst_hold", cv, '0);
    end
    release_reset();

    drive('{1, 2, 3}, '{4, 5, 6},
          '{4, 5, 6, 8, 10, 12, 12, 15, 18}, "basic");
    drive('{255, 255, 255}, '{255, 255, 255},
          '{65025, 65025, 65025, 65025, 65025,
            65025, 65025, 65025, 65025}, "max");
    drive('{0, 1, 7}, '{9, 1, 0},
          '{0, 0, 0, 9, 1, 0, 63, 7, 0}, "zero_id");
    drive('{2, 3, 4}, '{5, 6, 7},
          '{10, 12, 14, 15, 18, 21, 20, 24, 28}, "s0");
    drive('{10, 20, 30}, '{1, 2, 3},
          '{10, 20, 30, 20, 40, 60, 30, 60, 90}, "s1");
    drive('{128, 255, 16}, '{2, 255, 16},
          '{256, 32640, 2048, 510, 65025, 4080, 32, 4080, 256}, "s2");
    drain("directed");

    async_reset("rst_async");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cmp("rst_held", cv, '0);
    end
    release_reset();
    drive('{1, 1, 1}, '{200, 100, 50},
          '{200, 100, 50, 200, 100, 50, 200, 100, 50}, "ident");
    drain("after_rst");

    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 3; k++) begin
        ra[k] = int'($urandom_range(255));
        rb[k] = int'($urandom_range(255));
      end
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          re[3*i+j] = ra[i] * rb[j];
      drive(ra, rb, re, "rand");
    end
    async_reset("rst_midrun");
    @(negedge clk);
    cmp("rst_midrun_hold", cv, '0);
    release_reset();
    drive('{3, 5, 7}, '{11, 13, 17},
          '{33, 39, 51, 55, 65, 85, 77, 91, 119}, "restart");
    drain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/matrix_outer_mult.md
Name: matrix_outer_mult

Overview:
- Unsigned 3x3 outer-product multiplier: c = a ⊗ b, where a = {a1,a2,a3} and b = {b1,b2,b3}.
- Each of the nine outputs is one registered 8x8 product, zero-extended to 17 bits.
- Pipelined datapath block: accepts a new operand set every clock and has fixed latency, with no handshake.
- Used as the product-generation stage ahead of accumulation logic.

Parameters:
- DW, 8, operand width of a1..a3 and b1..b3.
- PW, 2*DW+1 (17), result width of c1..c9. The MSB is the headroom bit and is always 0 for raw products.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Assertion (0) clears all state immediately; deassertion is sampled on clk.
- a1  input  DW  row operand 1, unsigned.
- a2  input  DW  row operand 2, unsigned.
- a3  input  DW  row operand 3, unsigned.
- b1  input  DW  column operand 1, unsigned.
- b2  input  DW  column operand 2, unsigned.
- b3  input  DW  column operand 3, unsigned.
- c1  output  PW  a1*b1
- c2  output  PW  a1*b2
- c3  output  PW  a1*b3
- c4  output  PW  a2*b1
- c5  output  PW  a2*b2
- c6  output  PW  a2*b3
- c7  output  PW  a3*b1
- c8  output  PW  a3*b2
- c9  output  PW  a3*b3

Behaviour:
- Mapping: c[3*(i-1)+j] = ai * bj for i,j in 1..3 (row-major).
- Arithmetic: unsigned only. The product is 2*DW bits and is zero-extended to PW; bit PW-1 is always 0. No overflow or saturation is possible.
- Pipeline:
  - Stage 1 registers a1..a3 and b1..b3 on every rising clk.
  - Stage 2 registers the nine products.
  - Latency: operands present at rising edge N appear on c1..c9 after rising edge N+1 and stay stable until edge N+2.
  - Throughput: one operand set per cycle.
- No enable and no valid/ready: every clock edge captures whatever operands are present.
- Reset:
  - While reset=0, all stage-1 and stage-2 registers are 0, so c1..c9 = 0, asynchronously and immediately.
  - After reset deasserts, c1..c9 keep showing 0-based results until the pipeline refills: the first real result appears after the second rising edge.
- Reset mid-stream: in-flight operands are discarded and outputs go to 0 at once. There is no partial or stale result after release.
- Outputs are driven only from stage-2 flops, so no combinational path exists from inputs to outputs.
- Input changes between clock edges have no effect until the next edge.
- Boundaries:
  - Any operand 0 → the corresponding products are 0.
  - 255*255 → 65025 (17'h0FE01).
  - 1*x → x.

Decomposition:
- Shared package: DW and PW constants, and a localparam for the number of products (9).
- One sub-module is natural: mult_unit, an unsigned DW x DW multiplier with a PW zero-extended combinational output.
  - It is instantiated nine times by the top level.
  - The top level holds the stage-1 operand registers and the stage-2 result registers.

Test Plan:
1. Reset: hold reset=0 with a1=b1=255 and toggle clk → c1..c9 = 0 throughout. Assert reset asynchronously mid-cycle while outputs are nonzero → all outputs become 0 before the next edge.
2. Basic mapping: a=(1,2,3), b=(4,5,6) for one cycle → two edges later, c1..c9 = 4,5,6,8,10,12,12,15,18.
3. Max values: all operands 255 → every c = 65025, and bit 16 = 0.
4. Zeros/identity: a=(0,1,7), b=(9,1,0) → c = 0,0,0,9,1,0,63,7,0.
5. Back-to-back throughput: apply sets S0,S1,S2 on consecutive edges → outputs show products of S0,S1,S2 on consecutive cycles, delayed by 2 edges, with no bubbles.
6. Random regression: 20 random operand sets, one per clock → each c matches the software model of ai*bj at latency 2. Then reset=0 mid-run → all outputs 0, and the pipeline restarts cleanly after release.
